// File: rtl/control_sequencer_pkg.sv
// Shared constants for the control sequencer: control-word bit map, per-step
// control words, opcodes and the small decode helpers used by the top level.
package control_sequencer_pkg;

  localparam int BIT_CP   = 11;
  localparam int BIT_EP   = 10;
  localparam int BIT_LM_N = 9;
  localparam int BIT_CE_N = 8;
  localparam int BIT_LI_N = 7;
  localparam int BIT_EI_N = 6;
  localparam int BIT_LA_N = 5;
  localparam int BIT_EA   = 4;
  localparam int BIT_SU   = 3;
  localparam int BIT_EU   = 2;
  localparam int BIT_LB_N = 1;
  localparam int BIT_LO_N = 0;

  localparam logic [11:0] CW_IDLE      = 12'h3E3;
  localparam logic [11:0] CW_FETCH_T1  = 12'h5E3;
  localparam logic [11:0] CW_FETCH_T2  = 12'hBE3;
  localparam logic [11:0] CW_FETCH_T3  = 12'h263;
  localparam logic [11:0] CW_IR_TO_MAR = 12'h1A3;
  localparam logic [11:0] CW_RAM_TO_A  = 12'h2C3;
  localparam logic [11:0] CW_RAM_TO_B  = 12'h2E1;
  localparam logic [11:0] CW_ALU_ADD   = 12'h3C7;
  localparam logic [11:0] CW_ALU_SUB   = 12'h3CF;
  localparam logic [11:0] CW_A_TO_OUT  = 12'h3F2;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Sequencer mode flop: running the T-ring, or parked in HALT.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // step is the 1-based T-state number; 0 means no valid step.
  function automatic logic [11:0] cw_decode(input logic [3:0] step,
                                            input logic [3:0] op);
    logic [11:0] cw;
    cw = CW_IDLE;
    case (step)
      4'd1: cw = CW_FETCH_T1;
      4'd2: cw = CW_FETCH_T2;
      4'd3: cw = CW_FETCH_T3;
      4'd4: begin
        if (op == OP_LDA || op == OP_ADD || op == OP_SUB) cw = CW_IR_TO_MAR;
        else if (op == OP_OUT)                            cw = CW_A_TO_OUT;
      end
      4'd5: begin
        if (op == OP_LDA)                      cw = CW_RAM_TO_A;
        else if (op == OP_ADD || op == OP_SUB) cw = CW_RAM_TO_B;
      end
      4'd6: begin
        if (op == OP_ADD)      cw = CW_ALU_ADD;
        else if (op == OP_SUB) cw = CW_ALU_SUB;
      end
      default: cw = CW_IDLE;
    endcase
    return cw;
  endfunction

  // Last non-idle step of an instruction when returning early; 0 = run full ring.
  function automatic logic [3:0] early_last_step(input logic [3:0] op);
    logic [3:0] s;
    case (op)
      OP_LDA:         s = 4'd5;
      OP_OUT:         s = 4'd4;
      OP_ADD, OP_SUB: s = 4'd0;
      OP_HLT:         s = 4'd0;
      default:        s = 4'd3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the IR/datapath and the control sequencer.
interface control_sequencer_if #(
  parameter int NUM_T = 6
);
  // No handshake: opcode is sampled level-wise each cycle; ctrl_word, t_state
  // and halted are Moore outputs valid for the whole T-state and consumed at
  // the closing rising edge.
  logic [3:0]       opcode;
  logic [11:0]      ctrl_word;
  logic [NUM_T-1:0] t_state;
  logic             halted;

  modport master (
    input  opcode,
    output ctrl_word,
    output t_state,
    output halted
  );

  modport slave (
    output opcode,
    input  ctrl_word,
    input  t_state,
    input  halted
  );
endinterface

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring: clr and restart both force T1, advance rotates one step.
module control_sequencer_ring_counter #(
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             advance,
  input  logic             restart,
  output logic [NUM_T-1:0] ring
);

  localparam logic [NUM_T-1:0] RING_T1 = NUM_T'(1);

  always_ff @(posedge clk) begin
    if (clr)          ring <= RING_T1;
    else if (restart) ring <= RING_T1;
    else if (advance) ring <= {ring[NUM_T-2:0], ring[NUM_T-1]};
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: T-state ring plus HALT flop, decoding the latched
// opcode into the 12-bit datapath control word.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_T        = 6,
  parameter int EARLY_RETURN = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  control_sequencer_if.master  bus
);

  logic [NUM_T-1:0] ring;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [3:0]       step;
  logic [3:0]       last_step;
  logic             running;
  logic             restart;
  logic             enter_halt;

  function automatic logic [3:0] step_of(input logic [NUM_T-1:0] r);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < NUM_T; i++) begin
      if (r[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  assign step       = step_of(ring);
  assign running    = (state == ST_RUN);
  assign last_step  = early_last_step(bus.opcode);
  assign enter_halt = running && (step == 4'd4) && (bus.opcode == OP_HLT);
  assign restart    = (EARLY_RETURN != 0) && running && (last_step != 4'd0)
                      && (step == last_step);

  control_sequencer_ring_counter #(
    .NUM_T (NUM_T)
  ) u_ring (
    .clk     (clk),
    .clr     (clr),
    .advance (running),
    .restart (restart),
    .ring    (ring)
  );

  always_comb begin
    state_nxt = state;
    if (enter_halt) state_nxt = ST_HALT;
  end

  // clr takes priority over a simultaneous HLT entry.
  always_ff @(posedge clk) begin
    if (clr) state <= ST_RUN;
    else     state <= state_nxt;
  end

  // Forcing idle during clr keeps the bus quiet even before state is known.
  assign bus.ctrl_word = (clr || !running) ? CW_IDLE : cw_decode(step, bus.opcode);
  assign bus.t_state   = running ? ring : '0;
  assign bus.halted    = !running;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (EARLY_RETURN 0 and 1) run
// side by side against an independent step-table model.
module tb_control_sequencer;
  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] opcode;

  always #5 clk = ~clk;

  control_sequencer_if #(.NUM_T(6)) bus0 ();
  control_sequencer_if #(.NUM_T(6)) bus1 ();

  assign bus0.opcode = opcode;
  assign bus1.opcode = opcode;

  control_sequencer #(.NUM_T(6), .EARLY_RETURN(0)) dut0 (
    .clk (clk), .clr (clr), .bus (bus0.master)
  );
  control_sequencer #(.NUM_T(6), .EARLY_RETURN(1)) dut1 (
    .clk (clk), .clr (clr), .bus (bus1.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [18:0] exp_q[$];
  int          m_t[2];
  bit          m_h[2];
  bit          m_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_cw(input logic [3:0] op, input int t);
    logic [11:0] w;
    w = 12'h3E3;
    case (t)
      1: w = 12'h5E3;
      2: w = 12'hBE3;
      3: w = 12'h263;
      4: case (op)
           4'h0, 4'h1, 4'h2: w = 12'h1A3;
           4'hE:             w = 12'h3F2;
           default:          w = 12'h3E3;
         endcase
      5: case (op)
           4'h0:       w = 12'h2C3;
           4'h1, 4'h2: w = 12'h2E1;
           default:    w = 12'h3E3;
         endcase
      6: case (op)
           4'h1:    w = 12'h3C7;
           4'h2:    w = 12'h3CF;
           default: w = 12'h3E3;
         endcase
      default: w = 12'h3E3;
    endcase
    return w;
  endfunction

  function automatic bit is_last(input logic [3:0] op, input int t);
    case (op)
      4'h0:       return t == 5;
      4'hE:       return t == 4;
      4'h1, 4'h2: return t == 6;
      4'hF:       return t == 6;
      default:    return t == 3;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic c);
    logic [18:0] e;
    logic [11:0] cw_obs;
    logic [5:0]  ts_obs;
    logic        h_obs;
    string       nm;
    @(negedge clk);
    opcode = op;
    clr    = c;
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [5:0]  ts;
      logic [11:0] w;
      ts = m_h[i] ? 6'd0 : 6'(1 << (m_t[i] - 1));
      w  = (c || m_h[i]) ? 12'h3E3 : exp_cw(op, m_t[i]);
      exp_q.push_back({m_h[i], ts, w});
    end
    for (int i = 0; i < 2; i++) begin
      e      = exp_q.pop_front();
      cw_obs = (i == 0) ? bus0.ctrl_word : bus1.ctrl_word;
      ts_obs = (i == 0) ? bus0.t_state   : bus1.t_state;
      h_obs  = (i == 0) ? bus0.halted    : bus1.halted;
      nm     = (i == 0) ? "er0" : "er1";
      check_eq({nm, "_ctrl_word"}, 32'(cw_obs), 32'(e[11:0]));
      if (m_known) begin
        check_eq({nm, "_t_state"}, 32'(ts_obs), 32'(e[17:12]));
        check_eq({nm, "_halted"},  32'(h_obs),  32'(e[18]));
      end
    end
    // Advance the reference model across the coming rising edge.
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_t[i] = 1;
        m_h[i] = 1'b0;
      end else if (m_h[i]) begin
        m_h[i] = 1'b1;
      end else if (m_t[i] == 4 && op == 4'hF) begin
        m_h[i] = 1'b1;
      end else if (i == 1 && is_last(op, m_t[i])) begin
        m_t[i] = 1;
      end else begin
        m_t[i] = (m_t[i] == 6) ? 1 : m_t[i] + 1;
      end
    end
    if (c) m_known = 1'b1;
  endtask

  task automatic run_op(input logic [3:0] op, input int n);
    for (int k = 0; k < n; k++) drive(op, 1'b0);
  endtask

  initial begin
    clr    = 1'b1;
    opcode = 4'h0;
    m_t[0] = 1; m_t[1] = 1;
    m_h[0] = 1'b0; m_h[1] = 1'b0;

    drive(4'h0, 1'b1);
    drive(4'h0, 1'b1);
    run_op(4'h0, 7);
    drive(4'h0, 1'b1);
    run_op(4'h1, 6);
    run_op(4'h2, 6);
    drive(4'h0, 1'b1);
    run_op(4'hE, 6);
    drive(4'h0, 1'b1);
    run_op(4'h7, 6);
    drive(4'h0, 1'b1);
    run_op(4'hF, 16);
    drive(4'hF, 1'b1);
    run_op(4'h0, 2);
    // clr landing in T5 of an LDA
    drive(4'h0, 1'b1);
    run_op(4'h0, 4);
    drive(4'h0, 1'b1);
    run_op(4'h0, 3);
    // clr colliding with the HLT entry edge
    drive(4'h0, 1'b1);
    run_op(4'hF, 3);
    drive(4'hF, 1'b1);
    run_op(4'h1, 4);

    for (int k = 0; k < 300; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
      drive(op, ($urandom_range(0, 24) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Reader side of the instruction register: consumes the latched opcode (IR upper nibble) and sequences the machine through fetch and execute micro-steps.
- Holds a one-hot T-state ring counter plus a HALT state.
- Emits the 12-bit control word that drives every load and enable in the datapath: PC, MAR, RAM, IR, A, B, ALU and OUT.
- Sits between the IR and all datapath registers; it is the only source of their control strobes.

Parameters:
- NUM_T, 6, number of T-states per instruction (fixed fetch T1–T3; execute T4..T{NUM_T}); legal range 4..8.
- EARLY_RETURN, 0, when 1, the ring returns to T1 right after an instruction's last non-idle micro-step.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset, synchronous, active-high.
- opcode  input  4  instruction opcode from IR bits [7:4].
- ctrl_word  output  12  control word; bit map below.
- t_state  output  NUM_T  one-hot current T-state (debug/display).
- halted  output  1  high while in HALT state.

Behaviour:
- Control word bit map, active-low loads/enables as in datapath registers:
  - [11] CP, [10] EP, [9] LM_N, [8] CE_N, [7] LI_N, [6] EI_N, [5] LA_N, [4] EA, [3] SU, [2] EU, [1] LB_N, [0] LO_N.
  - CW_IDLE = 12'h3E3 (nothing drives the bus, nothing loads).
- Reset: clr high at a rising edge gives t_state = 1 (T1) and halted = 0. While clr is high, ctrl_word is forced combinationally to CW_IDLE, which prevents bus contention and counting during reset. Reset mid-instruction or in HALT aborts immediately.
- ctrl_word is Moore: decoded from registered state plus opcode. It is stable for the whole T-state, and the datapath latches at the closing rising edge.
- Ring: T1 → T2 → … → T{NUM_T} → T1, one step per clk.
- Fetch (opcode ignored):
  - T1 = 12'h5E3 (EP, LM_N).
  - T2 = 12'hBE3 (CP).
  - T3 = 12'h263 (CE_N, LI_N).
- Execute: opcode is read directly during T4..T{NUM_T}. The IR is stable there because LI_N is asserted only in T3.
  - LDA 4'h0: T4 12'h1A3 (LM_N, EI_N); T5 12'h2C3 (CE_N, LA_N); T6 idle.
  - ADD 4'h1: T4 12'h1A3; T5 12'h2E1 (CE_N, LB_N); T6 12'h3C7 (LA_N, EU).
  - SUB 4'h2: as ADD, except T6 = 12'h3CF (adds SU).
  - OUT 4'hE: T4 12'h3F2 (EA, LO_N); T5, T6 idle.
  - HLT 4'hF: in T4, ctrl_word = CW_IDLE. At the closing edge the sequencer enters HALT: halted = 1, t_state = 0, ctrl_word = CW_IDLE. It stays in HALT until clr.
  - Any other opcode: NOP, idle for T4..T{NUM_T}.
  - Steps beyond T6 (NUM_T > 6) are idle.
- EARLY_RETURN = 1: the edge closing the last active step goes to T1.
  - LDA after T5, OUT after T4, NOP after T3, ADD/SUB at full length.
  - HLT is unchanged.
- Simultaneous clr and HLT: clr wins, so the next state is T1.
- No output is X after the first clr edge. Before the first clr, state is undefined and the bench must reset.

Decomposition:
- Shared include control_defs.vh holds:
  - bit index localparams for the 12 control bits;
  - the CW_IDLE constant and the per-step control word constants;
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT.
- One natural sub-module, ring_counter: NUM_T-wide one-hot with sync clr, an advance input and a restart input. control_sequencer wraps it with the HALT flop and the decode logic.

Test Plan:
- Reset: clr = 1 for 2 cycles, then 0. Required: t_state = 6'b000001 and ctrl_word = 12'h3E3 while clr is high; 12'h5E3 in the first cycle after release.
- LDA: opcode = 4'h0 held, run 6 cycles. Required ctrl_word sequence: 5E3, BE3, 263, 1A3, 2C3, 3E3; then T1 again (5E3).
- ADD then SUB: opcode = 4'h1 for one 6-cycle pass, then 4'h2 for the next. Required T6 values: 12'h3C7, then 12'h3CF; T5 = 12'h2E1 in both passes.
- OUT and NOP: opcode = 4'hE gives T4 = 12'h3F2 and T5/T6 = 12'h3E3. opcode = 4'h7 gives T4–T6 = 12'h3E3.
- HLT: opcode = 4'hF. Required: halted = 1 from the cycle after T4; t_state = 0 and ctrl_word = 12'h3E3 for 10 or more cycles. clr pulse gives T1 and halted = 0.
- EARLY_RETURN = 1 with opcode = 4'h0: required sequence 5E3, BE3, 263, 1A3, 2C3, 5E3 (5-cycle instruction). Asserting clr in T5 gives T1 at the next edge.
